systolic_mac_array: RTL and testbench

//  Four-lane systolic MAC array with its own start-driven valid sequencer.
//  One start pulse walks a one-hot valid token across lanes 0..3, one lane per cycle.

---
 rtl/systolic_mac_array.sv | 125 ++++++++++++
 tb/tb_systolic_mac_array.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_mac_array.sv
// Four-lane systolic MAC array. A start pulse walks a one-hot token across the
// lanes; each lane can also fire from a forwarded operand or a partial-sum pass.
module systolic_mac_array #(
  parameter int W      = 8,
  parameter int ACC_W  = 16,
  parameter int N_MACS = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic signed [ACC_W-1:0] a_in,
  input  logic signed [ACC_W-1:0] w_0,
  input  logic signed [ACC_W-1:0] w_1,
  input  logic signed [ACC_W-1:0] w_2,
  input  logic signed [ACC_W-1:0] w_3,
  input  logic [3:0]              valid_in_1,
  input  logic [3:0]              valid_in_2,
  input  logic [3:0]              clear,
  output logic [3:0]              valid_ctrl,
  output logic                    busy,
  output logic signed [ACC_W-1:0] acc_out_0,
  output logic signed [ACC_W-1:0] acc_out_1,
  output logic signed [ACC_W-1:0] acc_out_2,
  output logic signed [ACC_W-1:0] acc_out_3,
  output logic [3:0]              valid_out
);

  typedef enum logic [2:0] {IDLE, S0, S1, S2, S3} state_t;

  state_t state_reg, state_next;

  logic signed [ACC_W-1:0] w_lane  [N_MACS];
  logic signed [ACC_W-1:0] acc_reg [N_MACS];
  logic signed [ACC_W-1:0] fwd_reg [N_MACS];
  logic                    vout_reg[N_MACS];

  // Low W bits of both operands multiplied as signed, then resized to ACC_W.
  function automatic logic signed [ACC_W-1:0] mac_product(
    input logic signed [W-1:0] op,
    input logic signed [W-1:0] wt
  );
    logic signed [2*W-1:0] prod;
    prod = op * wt;
    return ACC_W'(prod);
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    valid_ctrl = 4'b0000;
    case (state_reg)
      IDLE: if (start) state_next = S0;
      S0: begin valid_ctrl = 4'b0001; state_next = S1;   end
      S1: begin valid_ctrl = 4'b0010; state_next = S2;   end
      S2: begin valid_ctrl = 4'b0100; state_next = S3;   end
      S3: begin valid_ctrl = 4'b1000; state_next = IDLE; end
      default: state_next = IDLE;
    endcase
  end

  assign busy = (state_reg != IDLE);

  assign w_lane[0] = w_0;
  assign w_lane[1] = w_1;
  assign w_lane[2] = w_2;
  assign w_lane[3] = w_3;

  assign acc_out_0 = acc_reg[0];
  assign acc_out_1 = acc_reg[1];
  assign acc_out_2 = acc_reg[2];
  assign acc_out_3 = acc_reg[3];

  genvar gi;
  generate
    for (gi = 0; gi < N_MACS; gi++) begin : g_lane
      logic signed [ACC_W-1:0] op_prev;
      logic signed [ACC_W-1:0] sum_prev;

      // Lane 0 has no upstream neighbour: it takes a_in directly and adds zero.
      if (gi == 0) begin : g_first
        assign op_prev  = a_in;
        assign sum_prev = '0;
      end else begin : g_chain
        assign op_prev  = fwd_reg[gi-1];
        assign sum_prev = acc_reg[gi-1];
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          acc_reg[gi]  <= '0;
          fwd_reg[gi]  <= '0;
          vout_reg[gi] <= 1'b0;
        end else begin
          vout_reg[gi] <= 1'b0;
          if (clear[gi]) begin
            acc_reg[gi] <= '0;
          end else if (valid_ctrl[gi]) begin
            acc_reg[gi]  <= acc_reg[gi] + mac_product(a_in[W-1:0], w_lane[gi][W-1:0]);
            fwd_reg[gi]  <= a_in;
            vout_reg[gi] <= 1'b1;
          end else if (valid_in_1[gi]) begin
            acc_reg[gi]  <= acc_reg[gi] + mac_product(op_prev[W-1:0], w_lane[gi][W-1:0]);
            fwd_reg[gi]  <= op_prev;
            vout_reg[gi] <= 1'b1;
          end else if (valid_in_2[gi]) begin
            acc_reg[gi]  <= acc_reg[gi] + sum_prev;
            vout_reg[gi] <= 1'b1;
          end
        end
      end

      assign valid_out[gi] = vout_reg[gi];
    end
  endgenerate

  // Weight high bits and the last lane's forwarded high bits have no consumer.
  logic unused_bits;
  assign unused_bits = ^{w_0[ACC_W-1:W], w_1[ACC_W-1:W], w_2[ACC_W-1:W],
                         w_3[ACC_W-1:W], fwd_reg[N_MACS-1][ACC_W-1:W]};

endmodule

// File: tb/tb_systolic_mac_array.sv
// Directed bench for systolic_mac_array: a lane-level behavioural model checked
// every cycle, plus hand-computed literal expectations.
module tb_systolic_mac_array;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic signed [15:0] a_in;
  logic signed [15:0] wv[4];
  logic [3:0] valid_in_1, valid_in_2, clear;
  logic [3:0] valid_ctrl, valid_out;
  logic busy;
  logic signed [15:0] acc_out_0, acc_out_1, acc_out_2, acc_out_3;
  logic signed [15:0] dacc[4];

  int n_vec = 0;
  int n_err = 0;

  systolic_mac_array dut (
    .clk(clk), .rst(rst), .start(start), .a_in(a_in),
    .w_0(wv[0]), .w_1(wv[1]), .w_2(wv[2]), .w_3(wv[3]),
    .valid_in_1(valid_in_1), .valid_in_2(valid_in_2), .clear(clear),
    .valid_ctrl(valid_ctrl), .busy(busy),
    .acc_out_0(acc_out_0), .acc_out_1(acc_out_1),
    .acc_out_2(acc_out_2), .acc_out_3(acc_out_3),
    .valid_out(valid_out)
  );

  assign dacc[0] = acc_out_0;
  assign dacc[1] = acc_out_1;
  assign dacc[2] = acc_out_2;
  assign dacc[3] = acc_out_3;

  always #5 clk = ~clk;

  task automatic cmp(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int m_pos = -1;  // token lane, -1 when no sweep is running
  logic signed [15:0] m_acc[4] = '{default: 16'sd0};
  logic signed [15:0] m_fwd[4] = '{default: 16'sd0};
  logic [3:0] m_vout = 4'b0000;

  function automatic logic signed [15:0] prod16(input logic signed [15:0] op,
                                                 input logic signed [15:0] wt);
    logic signed [7:0] a8, b8;
    int p;
    a8 = op[7:0];
    b8 = wt[7:0];
    p  = int'(a8) * int'(b8);
    return 16'(p);
  endfunction

  always @(posedge clk or posedge rst) begin
    logic signed [15:0] oa[4];
    logic signed [15:0] of[4];
    logic signed [15:0] op_prev, sum_prev;
    if (rst) begin
      m_pos = -1;
      m_vout = 4'b0000;
      for (int i = 0; i < 4; i++) begin m_acc[i] = 0; m_fwd[i] = 0; end
    end else begin
      oa = m_acc;
      of = m_fwd;
      for (int i = 0; i < 4; i++) begin
        m_vout[i] = 1'b0;
        op_prev  = (i == 0) ? a_in : of[i-1];
        sum_prev = (i == 0) ? 16'sd0 : oa[i-1];
        if (clear[i]) m_acc[i] = 0;
        else if (m_pos == i) begin
          m_acc[i] = oa[i] + prod16(a_in, wv[i]); m_fwd[i] = a_in; m_vout[i] = 1'b1;
        end else if (valid_in_1[i]) begin
          m_acc[i] = oa[i] + prod16(op_prev, wv[i]); m_fwd[i] = op_prev; m_vout[i] = 1'b1;
        end else if (valid_in_2[i]) begin
          m_acc[i] = oa[i] + sum_prev; m_vout[i] = 1'b1;
        end
      end
      if (m_pos < 0) m_pos = start ? 0 : -1;
      else           m_pos = (m_pos == 3) ? -1 : m_pos + 1;
    end
  end

  // Cycle-by-cycle compare against the model.
  always @(negedge clk) begin
    logic [3:0] exp_tok;
    exp_tok = (m_pos >= 0) ? 4'(1 << m_pos) : 4'b0000;
    for (int i = 0; i < 4; i++) cmp($sformatf("acc_out_%0d", i), int'(dacc[i]), int'(m_acc[i]));
    cmp("valid_out", int'(valid_out), int'(m_vout));
    cmp("valid_ctrl", int'(valid_ctrl), int'(exp_tok));
    cmp("busy", int'(busy), (m_pos >= 0) ? 1 : 0);
  end

  // ---------------- stimulus ----------------
  int sw_busy, sw_t0, sw_t1, sw_tok, sw_n0, sw_n1;

  task automatic sweep(input bit repulse);
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    sw_busy = 0; sw_t0 = -1; sw_t1 = -1; sw_tok = 0; sw_n0 = 0; sw_n1 = 0;
    for (int k = 0; k < 8; k++) begin
      if (busy) sw_busy++;
      sw_tok += $countones(valid_ctrl);
      if (valid_out[0]) begin sw_n0++; if (sw_t0 < 0) sw_t0 = k; end
      if (valid_out[1]) begin sw_n1++; if (sw_t1 < 0) sw_t1 = k; end
      start = repulse && (k == 1 || k == 3);
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  task automatic pulse(input logic [3:0] c, input logic [3:0] v1, input logic [3:0] v2);
    @(negedge clk);
    clear = c; valid_in_1 = v1; valid_in_2 = v2;
    @(negedge clk);
    clear = 4'b0; valid_in_1 = 4'b0; valid_in_2 = 4'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; start = 1'b0; a_in = 0;
    wv = '{default: 16'sd0};
    valid_in_1 = 4'b0; valid_in_2 = 4'b0; clear = 4'b0;
    repeat (3) @(negedge clk);
    cmp("rst_acc0", int'(acc_out_0), 0);
    cmp("rst_acc3", int'(acc_out_3), 0);
    cmp("rst_vout", int'(valid_out), 0);
    cmp("rst_busy", int'(busy), 0);
    cmp("rst_vctrl", int'(valid_ctrl), 0);
    rst = 1'b0;

    // First sweep: 10*2 and 10*3.
    a_in = 10; wv[0] = 2; wv[1] = 3;
    sweep(1'b0);
    cmp("s1_busy_cycles", sw_busy, 4);
    cmp("s1_vout0_time", sw_t0, 1);
    cmp("s1_vout1_time", sw_t1, 2);
    cmp("s1_acc0", int'(acc_out_0), 20);
    cmp("s1_acc1", int'(acc_out_1), 30);

    // Second sweep accumulates without clear.
    a_in = 5;
    sweep(1'b0);
    cmp("s2_acc0", int'(acc_out_0), 30);
    cmp("s2_acc1", int'(acc_out_1), 45);
    cmp("s2_n0", sw_n0, 1);
    cmp("s2_n1", sw_n1, 1);
    cmp("s2_order", sw_t1 - sw_t0, 1);

    // Clear lanes 0/1, then negative activation.
    pulse(4'b0011, 4'b0, 4'b0);
    a_in = -4;
    sweep(1'b0);
    cmp("neg_acc0", int'(acc_out_0), -8);
    cmp("neg_acc1", int'(acc_out_1), -12);

    // Wrap: 3 * 127*127 = 48387 -> -17149 modulo 2^16.
    pulse(4'b0001, 4'b0, 4'b0);
    a_in = 127; wv[0] = 127;
    @(negedge clk) valid_in_1 = 4'b0001;
    repeat (3) @(negedge clk);
    valid_in_1 = 4'b0;
    @(negedge clk);
    cmp("wrap_acc0", int'(acc_out_0), -17149);

    // start re-pulsed while busy is ignored.
    a_in = 1;
    sweep(1'b1);
    cmp("repulse_tokens", sw_tok, 4);
    cmp("repulse_busy", sw_busy, 4);

    // Forwarded operand: lane 0 fires with 7, lane 1 then uses it with w=3.
    a_in = 7; wv[1] = 3;
    pulse(4'b0010, 4'b0, 4'b0);
    @(negedge clk) valid_in_1 = 4'b0001;
    @(negedge clk) valid_in_1 = 4'b0010; a_in = 0;
    @(negedge clk) valid_in_1 = 4'b0;
    @(negedge clk);
    cmp("fwd_acc1", int'(acc_out_1), 21);

    // Partial-sum pass on all lanes (model-checked), with a mixed weight set.
    wv[2] = -3; wv[3] = 16'sh0105;
    pulse(4'b0000, 4'b0000, 4'b1111);
    a_in = -2;
    sweep(1'b0);
    pulse(4'b0000, 4'b1100, 4'b0011);

    // Reset asserted while the token sits in S2.
    a_in = 10; wv[0] = 2;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    cmp("mid_rst_busy", int'(busy), 0);
    cmp("mid_rst_vctrl", int'(valid_ctrl), 0);
    cmp("mid_rst_acc0", int'(acc_out_0), 0);
    cmp("mid_rst_acc1", int'(acc_out_1), 0);
    cmp("mid_rst_vout", int'(valid_out), 0);
    @(negedge clk);
    rst = 1'b0;
    sweep(1'b0);
    cmp("fresh_busy", sw_busy, 4);
    cmp("fresh_t0", sw_t0, 1);
    cmp("fresh_acc0", int'(acc_out_0), 20);

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
